// File: rtl/snake_pkg.sv
// Shared constants for the snake game counter datapath.
package snake_pkg;

    // Count direction encodings for the dir input
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    // Boundary behaviour encodings for the mode_sat input
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : snake_pkg

// File: rtl/edge_pulser.sv
// Rising-edge detector. The history register resets to 1 so that an input
// already high when reset is released is not reported as a fresh edge.
module edge_pulser (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

    logic q_r;

    // Track the previous value of d; history is forced high during reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q_r <= 1'b1;
        end else begin
            q_r <= d;
        end
    end

    assign pulse = d & ~q_r;

endmodule : edge_pulser

// File: rtl/snake_wrap_counter.sv
// Parametrised up/down modulo or saturating counter with parallel load and a
// registered wrap pulse for cascading (grid position, tick dividers, score).
module snake_wrap_counter
    import snake_pkg::*;
#(
    parameter int                 WIDTH     = 10,
    parameter bit                 EDGE_EN   = 1'b1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] max,
    input  logic             en,
    input  logic             dir,
    input  logic             mode_sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_max
);

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    logic             step_s;
    logic [WIDTH-1:0] count_nxt_s;
    logic             wrap_nxt_s;

    // Step source: one step per en rising edge, or one per cycle en is high
    generate
        if (EDGE_EN) begin : g_edge
            edge_pulser u_edge_pulser (
                .clock   (clock),
                .reset_n (reset_n),
                .d       (en),
                .pulse   (step_s)
            );
        end else begin : g_level
            assign step_s = en;
        end
    endgenerate

    // Next count and wrap: load beats step; boundary test precedes arithmetic
    always_comb begin
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
        if (load) begin
            if (load_val > max) begin
                count_nxt_s = max;
            end else begin
                count_nxt_s = load_val;
            end
        end else if (step_s) begin
            case (dir)
                DIR_UP: begin
                    if (count_r < max) begin
                        count_nxt_s = count_r + WIDTH'(1);
                    end else if (mode_sat == MODE_WRAP) begin
                        count_nxt_s = '0;
                        wrap_nxt_s  = 1'b1;
                    end else begin
                        count_nxt_s = count_r;
                    end
                end
                DIR_DOWN: begin
                    // Out-of-range count (max shrunk at runtime) clamps first
                    if (count_r > max) begin
                        count_nxt_s = max;
                    end else if (count_r != '0) begin
                        count_nxt_s = count_r - WIDTH'(1);
                    end else if (mode_sat == MODE_SAT) begin
                        count_nxt_s = count_r;
                    end else begin
                        count_nxt_s = max;
                        wrap_nxt_s  = 1'b1;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count and wrap state registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_r <= RESET_VAL;
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

    assign count  = count_r;
    assign wrap   = wrap_r;
    assign at_max = (count_r == max);

endmodule : snake_wrap_counter

// File: tb/tb_snake_wrap_counter.sv
// Directed bench: vector table for the edge-triggered 10-bit counter, plus a
// hand-written level-mode run on a 4-bit instance.
module tb_snake_wrap_counter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Edge-mode instance (WIDTH=10)
    logic       a_rn, a_en, a_dir, a_sat, a_ld;
    logic [9:0] a_lv, a_max, a_count;
    logic       a_wrap, a_at_max;

    snake_wrap_counter #(.WIDTH(10), .EDGE_EN(1'b1), .RESET_VAL(10'd0)) u_a (
        .clock    (clk),
        .reset_n  (a_rn),
        .max      (a_max),
        .en       (a_en),
        .dir      (a_dir),
        .mode_sat (a_sat),
        .load     (a_ld),
        .load_val (a_lv),
        .count    (a_count),
        .wrap     (a_wrap),
        .at_max   (a_at_max)
    );

    // Level-mode instance (WIDTH=4)
    logic       b_rn, b_en, b_dir, b_sat, b_ld;
    logic [3:0] b_lv, b_max, b_count;
    logic       b_wrap, b_at_max;

    snake_wrap_counter #(.WIDTH(4), .EDGE_EN(1'b0), .RESET_VAL(4'd0)) u_b (
        .clock    (clk),
        .reset_n  (b_rn),
        .max      (b_max),
        .en       (b_en),
        .dir      (b_dir),
        .mode_sat (b_sat),
        .load     (b_ld),
        .load_val (b_lv),
        .count    (b_count),
        .wrap     (b_wrap),
        .at_max   (b_at_max)
    );

    typedef struct {
        logic       rn;
        logic       en;
        logic       dir;
        logic       sat;
        logic       ld;
        logic [9:0] lv;
        logic [9:0] mx;
        logic [9:0] e_count;
        logic       e_wrap;
        logic       e_at_max;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rn, input logic en, input logic dir,
                       input logic sat, input logic ld, input int lv,
                       input int mx, input int ec, input logic ew,
                       input logic ea);
        vec_t v;
        v.rn = rn; v.en = en; v.dir = dir; v.sat = sat; v.ld = ld;
        v.lv = 10'(lv); v.mx = 10'(mx);
        v.e_count = 10'(ec); v.e_wrap = ew; v.e_at_max = ea;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int got,
                       input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, got, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        a_rn = 1'b0; a_en = 1'b1; a_dir = 1'b0; a_sat = 1'b0; a_ld = 1'b0;
        a_lv = 10'd0; a_max = 10'd3;
        b_rn = 1'b0; b_en = 1'b0; b_dir = 1'b0; b_sat = 1'b0; b_ld = 1'b0;
        b_lv = 4'd0; b_max = 4'd15;

        //  rn  en  dir sat ld  lv    mx    count wrap at_max
        // reset with en held high, then release: no count until a fresh rise
        add(1'b0,1'b1,1'b0,1'b0,1'b0, 0,    3,    0, 1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0, 0,    3,    0, 1'b0,1'b0);
        add(1'b1,1'b1,1'b0,1'b0,1'b0, 0,    3,    0, 1'b0,1'b0);
        add(1'b1,1'b1,1'b0,1'b0,1'b0, 0,    3,    0, 1'b0,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0, 0,    3,    0, 1'b0,1'b0);
        // wrap up, max=3: 1,2,3,0,1
        add(1'b1,1'b1,1'b0,1'b0,1'b0, 0,    3,    1, 1'b0,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0, 0,    3,    1, 1'b0,1'b0);
        add(1'b1,1'b1,1'b0,1'b0,1'b0, 0,    3,    2, 1'b0,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0, 0,    3,    2, 1'b0,1'b0);
        add(1'b1,1'b1,1'b0,1'b0,1'b0, 0,    3,    3, 1'b0,1'b1);
        add(1'b1,1'b0,1'b0,1'b0,1'b0, 0,    3,    3, 1'b0,1'b1);
        add(1'b1,1'b1,1'b0,1'b0,1'b0, 0,    3,    0, 1'b1,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0, 0,    3,    0, 1'b0,1'b0);
        add(1'b1,1'b1,1'b0,1'b0,1'b0, 0,    3,    1, 1'b0,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0, 0,    3,    1, 1'b0,1'b0);
        // load 2 with max=5, then count down saturating: 1,0,0,0
        add(1'b1,1'b0,1'b0,1'b0,1'b1, 2,    5,    2, 1'b0,1'b0);
        add(1'b1,1'b1,1'b1,1'b1,1'b0, 0,    5,    1, 1'b0,1'b0);
        add(1'b1,1'b0,1'b1,1'b1,1'b0, 0,    5,    1, 1'b0,1'b0);
        add(1'b1,1'b1,1'b1,1'b1,1'b0, 0,    5,    0, 1'b0,1'b0);
        add(1'b1,1'b0,1'b1,1'b1,1'b0, 0,    5,    0, 1'b0,1'b0);
        add(1'b1,1'b1,1'b1,1'b1,1'b0, 0,    5,    0, 1'b0,1'b0);
        add(1'b1,1'b0,1'b1,1'b1,1'b0, 0,    5,    0, 1'b0,1'b0);
        add(1'b1,1'b1,1'b1,1'b1,1'b0, 0,    5,    0, 1'b0,1'b0);
        add(1'b1,1'b0,1'b1,1'b1,1'b0, 0,    5,    0, 1'b0,1'b0);
        // switch to wrap: down from 0 wraps to max
        add(1'b1,1'b1,1'b1,1'b0,1'b0, 0,    5,    5, 1'b1,1'b1);
        add(1'b1,1'b0,1'b1,1'b0,1'b0, 0,    5,    5, 1'b0,1'b1);
        // load clamp with coincident en rise; rise consumed by load
        add(1'b1,1'b1,1'b0,1'b0,1'b1, 12,   8,    8, 1'b0,1'b1);
        add(1'b1,1'b1,1'b0,1'b0,1'b0, 0,    8,    8, 1'b0,1'b1);
        add(1'b1,1'b0,1'b0,1'b0,1'b0, 0,    8,    8, 1'b0,1'b1);
        // max shrinks below count: up step wraps to 0
        add(1'b1,1'b0,1'b0,1'b0,1'b1, 7,    8,    7, 1'b0,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0, 0,    4,    7, 1'b0,1'b0);
        add(1'b1,1'b1,1'b0,1'b0,1'b0, 0,    4,    0, 1'b1,1'b0);
        // max shrinks below count: down step clamps to max, no wrap
        add(1'b1,1'b0,1'b0,1'b0,1'b1, 7,    8,    7, 1'b0,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0, 0,    4,    7, 1'b0,1'b0);
        add(1'b1,1'b1,1'b1,1'b0,1'b0, 0,    4,    4, 1'b0,1'b1);
        add(1'b1,1'b0,1'b1,1'b0,1'b0, 0,    4,    4, 1'b0,1'b1);
        // max == 0: every step wraps, count stays 0
        add(1'b1,1'b0,1'b0,1'b0,1'b1, 5,    0,    0, 1'b0,1'b1);
        add(1'b1,1'b1,1'b0,1'b0,1'b0, 0,    0,    0, 1'b1,1'b1);
        add(1'b1,1'b0,1'b0,1'b0,1'b0, 0,    0,    0, 1'b0,1'b1);
        add(1'b1,1'b1,1'b1,1'b0,1'b0, 0,    0,    0, 1'b1,1'b1);
        add(1'b1,1'b0,1'b1,1'b0,1'b0, 0,    0,    0, 1'b0,1'b1);
        // max all-ones: wrap up and saturate up
        add(1'b1,1'b0,1'b0,1'b0,1'b1, 1023, 1023, 1023, 1'b0,1'b1);
        add(1'b1,1'b1,1'b0,1'b0,1'b0, 0,    1023, 0,    1'b1,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b1, 1023, 1023, 1023, 1'b0,1'b1);
        add(1'b1,1'b1,1'b0,1'b1,1'b0, 0,    1023, 1023, 1'b0,1'b1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            a_rn = vq[i].rn; a_en = vq[i].en; a_dir = vq[i].dir;
            a_sat = vq[i].sat; a_ld = vq[i].ld; a_lv = vq[i].lv;
            a_max = vq[i].mx;
            @(posedge clk);
            #1;
            chk("a_count",  i, int'(a_count),  int'(vq[i].e_count));
            chk("a_wrap",   i, int'(a_wrap),   int'(vq[i].e_wrap));
            chk("a_at_max", i, int'(a_at_max), int'(vq[i].e_at_max));
        end

        // Level mode: reset, then en high for 18 cycles
        @(negedge clk);
        b_rn = 1'b0; b_en = 1'b0;
        @(posedge clk);
        #1;
        chk("b_reset_count", 0, int'(b_count), 0);
        chk("b_reset_wrap",  0, int'(b_wrap),  0);
        @(negedge clk);
        b_rn = 1'b1; b_en = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            chk("b_level_count", k, int'(b_count), k % 16);
            chk("b_level_wrap",  k, int'(b_wrap),  (k == 16) ? 1 : 0);
        end
        chk("b_level_end", 18, int'(b_count), 2);

        // One-cycle reset in the middle of a level run
        @(negedge clk);
        b_rn = 1'b0;
        @(posedge clk);
        #1;
        chk("b_midreset_count", 0, int'(b_count), 0);
        @(negedge clk);
        b_rn = 1'b1;
        @(posedge clk);
        #1;
        chk("b_after_reset_count", 1, int'(b_count), 1);
        chk("b_after_reset_wrap",  1, int'(b_wrap),  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_snake_wrap_counter
